// File: rtl/rotary_selector.sv
// Rotary encoder selector: synchronizes a quadrature encoder, decodes
// steps, divides them by STEPS per detent and moves a bounded value
// that either wraps or saturates at the ends of 0..MAX_VAL.
module rotary_selector #(
    parameter int VAL_W     = 5,
    parameter int MAX_VAL   = 25,
    parameter int STEPS     = 4,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [VAL_W-1:0] load_val,
    input  logic             rotary_a,
    input  logic             rotary_b,
    output logic [VAL_W-1:0] value,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             wrap_pulse,
    output logic             quad_err
);

    localparam int               SUB_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS - 1);
    localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
    localparam logic [VAL_W-1:0] RST_V    = VAL_W'(RESET_VAL);

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_CW,
        STEP_CCW,
        STEP_ILLEGAL
    } step_e;

    logic             a_meta_q, a_sync_q, b_meta_q, b_sync_q;
    logic [1:0]       prev_ab_q;
    logic [1:0]       cur_ab;
    step_e            step;

    logic [VAL_W-1:0] value_q, value_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             wrap_q, wrap_d;
    logic             qerr_q, qerr_d;

    // Two-flop synchronizers plus the previous-phase register; these run
    // through reset so the first decoded pair after reset is already valid.
    // NOTE: flops are written with non-blocking assignments so every
    // register samples the pre-edge value of its source.
    always_ff @(posedge clock) begin
        a_meta_q  <= rotary_a;
        a_sync_q  <= a_meta_q;
        b_meta_q  <= rotary_b;
        b_sync_q  <= b_meta_q;
        prev_ab_q <= cur_ab;
    end

    assign cur_ab = {a_sync_q, b_sync_q};

    // Classify the phase transition between last cycle and this cycle.
    // NOTE: every signal driven in an always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        step = STEP_NONE;
        case ({prev_ab_q, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_CW;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_CCW;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ILLEGAL;
            default:                                 step = STEP_NONE;
        endcase
    end

    // Next value, sub-step count and pulses; load beats any step.
    always_comb begin
        value_d = value_q;
        sub_d   = sub_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        wrap_d  = 1'b0;
        qerr_d  = (step == STEP_ILLEGAL);
        if (load) begin
            value_d = (load_val > MAX_V) ? MAX_V : load_val;
            sub_d   = '0;
        end else if (enable && step == STEP_CW) begin
            if (sub_q < SUB_LAST) begin
                sub_d = sub_q + SUB_W'(1);
            end else if (value_q < MAX_V) begin
                sub_d   = '0;
                value_d = value_q + VAL_W'(1);
                inc_d   = 1'b1;
            end else if (WRAP != 0) begin
                sub_d   = '0;
                value_d = '0;
                inc_d   = 1'b1;
                wrap_d  = 1'b1;
            end else begin
                // Saturated at the top: stay one click away from advancing.
                sub_d = SUB_LAST;
            end
        end else if (enable && step == STEP_CCW) begin
            if (sub_q > '0) begin
                sub_d = sub_q - SUB_W'(1);
            end else if (value_q > '0) begin
                sub_d   = SUB_LAST;
                value_d = value_q - VAL_W'(1);
                dec_d   = 1'b1;
            end else if (WRAP != 0) begin
                sub_d   = SUB_LAST;
                value_d = MAX_V;
                dec_d   = 1'b1;
                wrap_d  = 1'b1;
            end else begin
                // Saturated at the bottom: stay one click away from retreating.
                sub_d = '0;
            end
        end
    end

    // Output and sub-step registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= RST_V;
            sub_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            wrap_q  <= 1'b0;
            qerr_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            sub_q   <= sub_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            wrap_q  <= wrap_d;
            qerr_q  <= qerr_d;
        end
    end

    assign value      = value_q;
    assign inc_pulse  = inc_q;
    assign dec_pulse  = dec_q;
    assign wrap_pulse = wrap_q;
    assign quad_err   = qerr_q;

endmodule
